// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store data memory: access-size encodings
// and the byte-lane helpers used on the request side.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Byte-enable for an access of 2**size bytes starting at lane off.
  // Sized for the widest word (8 lanes); callers truncate to their lane count.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // True when the lane offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      default: bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Response-side load formatting: pick the addressed lane out of the RAM word
// and zero- or sign-extend it to the full data width.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             rdata_i,
  input  logic [$clog2(DATA_W/8)-1:0]   off_i,
  input  logic [1:0]                    size_i,
  input  logic                          unsigned_i,
  output logic [DATA_W-1:0]             data_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign;

  // Shift the lane down to bit 0, mask to the access size, then extend.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    keep    = '1;
    sign    = 1'b0;
    case (size_i)
      SZ_B: begin
        keep = DATA_W'(8'hFF);
        sign = shifted[7];
      end
      SZ_H: begin
        keep = DATA_W'(16'hFFFF);
        sign = shifted[15];
      end
      SZ_W: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        keep = '1;
        sign = 1'b0;
      end
    endcase
    data_o = shifted & keep;
    if (!unsigned_i && sign) begin
      data_o = data_o | ~keep;
    end
  end

endmodule

// File: rtl/dmem_lsu_bram.sv
// Data memory for the MEM stage: block-RAM array behind a valid/ready
// request/response pair, with byte/half/word/dword stores, formatted loads
// and misalignment reporting. One request per cycle, response one cycle later.
module dmem_lsu_bram
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic              resp_valid_q;
  logic              err_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [LANE_W-1:0] off_q;

  logic              accept;
  logic [LANE_W-1:0] offset;
  logic [IDX_W-1:0]  index;
  logic              err_d;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] load_data;
  logic              unused_addr_hi;

  assign req_ready = !rst && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;

  assign offset         = req_addr[LANE_W-1:0];
  assign index          = req_addr[LANE_W +: IDX_W];
  assign unused_addr_hi = ^req_addr[ADDR_W-1:LANE_W+IDX_W];

  // A dword only exists on a 64-bit memory.
  assign err_d    = misaligned(req_size, 3'(offset)) || (req_size == SZ_D && DATA_W != 64);
  assign be       = NB'(be_mask(req_size, 3'(offset)));
  assign wdata_sh = req_wdata << {offset, 3'b000};

  // RAM: per-byte write on the accept edge; read register only moves on accept so it holds during a stall.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err_d) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[index][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
    if (accept) begin
      rdata_q <= mem[index];
    end
  end

  // Response valid/err: set on accept, cleared once consumed, dropped by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      err_q        <= err_d;
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  // Access attributes registered alongside the RAM read for response-side formatting.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q   <= req_we;
      uns_q  <= req_unsigned;
      size_q <= req_size;
      off_q  <= offset;
    end
  end

  dmem_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata_i    (rdata_q),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_valid_q && err_q;
  assign resp_rdata = (resp_valid_q && !err_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_dmem_lsu_bram.sv
// Scoreboard bench for dmem_lsu_bram: a byte-array reference model produces the
// expected response at acceptance; a monitor checks every presented response.
module tb_dmem_lsu_bram;

  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  int tests  = 0;
  int fails  = 0;
  int rr_mode = 0;   // 0: always ready, 1: random, 2: held low

  logic [7:0] mem_m [DEPTH*NB];
  exp_t       sb_q [$];

  dmem_lsu_bram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = ($urandom % 4) != 0;
      default: resp_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, wrap modulo DEPTH words.
  function automatic exp_t model(input bit we, input logic [AW-1:0] addr, input logic [1:0] size,
                                 input bit uns, input logic [DW-1:0] wd);
    exp_t        r;
    int          off;
    int          idx;
    int          n;
    logic [63:0] v;
    off = int'(addr % NB);
    idx = int'((addr / NB) % DEPTH);
    n   = 1 << size;
    r.err  = 1'b0;
    r.data = '0;
    if ((size == 2'd3) || (off % n != 0)) begin
      r.err = 1'b1;
      return r;
    end
    if (we) begin
      for (int i = 0; i < n; i++) mem_m[idx*NB + off + i] = wd[8*i +: 8];
      return r;
    end
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(mem_m[idx*NB + off + i]) << (8*i));
    if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    r.data = v[DW-1:0];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [1:0] size,
                       input bit uns, input logic [DW-1:0] wd);
    int waitc = 0;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout: req_ready stuck at 0 for addr 0x%08h", addr);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(model(we, addr, size, uns, wd));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (sb_q.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: compare every presented response against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got err=%0b data=0x%08h, expected no response", resp_err, resp_rdata);
      end else begin
        check("resp_err", DW'(resp_err), DW'(sb_q[0].err));
        check("resp_rdata", resp_rdata, sb_q[0].data);
        if (resp_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a;
    logic [1:0]    sz;
    // Reset for 3 cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_resp_valid", DW'(resp_valid), '0);
    check("reset_req_ready", DW'(req_ready), DW'(1));
    check("reset_resp_err", DW'(resp_err), '0);
    check("reset_resp_rdata", resp_rdata, '0);

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++) issue(1'b1, AW'(w*NB), 2'd2, 1'b0, DW'($urandom));

    // Word store, then signed byte and unsigned half loads.
    issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 32'h13, 2'd0, 1'b0, '0);
    issue(1'b0, 32'h12, 2'd1, 1'b1, '0);

    // Byte store into a cleared word.
    issue(1'b1, 32'h20, 2'd2, 1'b0, 32'h0);
    issue(1'b1, 32'h21, 2'd0, 1'b0, 32'h5A);
    issue(1'b0, 32'h20, 2'd2, 1'b0, '0);

    // Back-to-back store then load of the same word.
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'h1234_5678);
    issue(1'b0, 32'h40, 2'd2, 1'b0, '0);
    issue(1'b1, 32'h42, 2'd1, 1'b0, 32'hFFFF_8001);
    issue(1'b0, 32'h42, 2'd1, 1'b0, '0);
    issue(1'b0, 32'h40, 2'd2, 1'b1, '0);

    // Misaligned half store leaves memory alone; dword is illegal on 32 bits.
    issue(1'b1, 32'h03, 2'd1, 1'b0, 32'hAAAA_BBBB);
    issue(1'b0, 32'h00, 2'd2, 1'b0, '0);
    issue(1'b0, 32'h08, 2'd3, 1'b0, '0);
    issue(1'b1, 32'h0A, 2'd2, 1'b0, 32'h5555_5555);
    issue(1'b0, 32'h08, 2'd2, 1'b0, '0);
    drain();

    // Randomized traffic with random response backpressure.
    rr_mode = 1;
    for (int i = 0; i < 500; i++) begin
      a  = AW'($urandom_range(0, DEPTH*NB*3 - 1));
      sz = 2'($urandom_range(0, 3));
      if ($urandom % 4 != 0) a = a & ~((AW'(1) << sz) - AW'(1));
      issue(($urandom % 2) == 1, a, sz, ($urandom % 2) == 1, DW'($urandom));
    end
    rr_mode = 0;
    drain();

    // Stall with a load pending, then reset mid-stall.
    rr_mode = 2;
    @(posedge clk);
    @(negedge clk);
    issue(1'b0, 32'h10, 2'd2, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      check("stall_req_ready", DW'(req_ready), '0);
      check("stall_resp_valid", DW'(resp_valid), DW'(1));
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_drop_resp_valid", DW'(resp_valid), '0);
    check("rst_req_ready", DW'(req_ready), '0);
    sb_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    rr_mode = 0;
    @(negedge clk);
    check("post_rst_req_ready", DW'(req_ready), DW'(1));

    // Address DEPTH*4 wraps to word 0.
    issue(1'b1, AW'(DEPTH*NB), 2'd2, 1'b0, 32'hCAFE_F00D);
    issue(1'b0, 32'h0, 2'd2, 1'b0, '0);
    issue(1'b0, AW'(DEPTH*NB + 2), 2'd1, 1'b1, '0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
